// File: rtl/pulseox_pkg.sv
// Shared types and widths for the pulse-oximeter front end.
// AMBIENT_PHASE_EN adds a dark (ambient) phase after IR.
`timescale 1ns/1ps
package pulseox_pkg;
  localparam int ADC_W  = 8;
  localparam int DC_W   = 7;
  localparam int GAIN_W = 4;

  typedef enum logic [1:0] {
    RED = 2'd0,
    IR  = 2'd1,
    AMB = 2'd2
  } chan_e;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    DWELL
  } sched_st_e;

  function automatic chan_e next_chan(chan_e c);
`ifdef AMBIENT_PHASE_EN
    chan_e n;
    unique case (c)
      RED:     n = IR;
      IR:      n = AMB;
      default: n = RED;
    endcase
    return n;
`else
    return (c == RED) ? IR : RED;
`endif
  endfunction
endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter with settle-done and phase-end strobes.
// Counter holds at zero while not running and wraps at phase end.
`timescale 1ns/1ps
module phase_timer #(
  parameter int SETTLE_CYC = 16,
  parameter int PHASE_CYC  = 40,
  parameter int CW         = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic i_run,
  output logic o_settle_done,
  output logic o_phase_end
);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [CW-1:0] PHASE_LAST  = CW'(PHASE_CYC - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_run || o_phase_end) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_settle_done = i_run && (r_cnt == SETTLE_LAST);
  assign o_phase_end   = i_run && (r_cnt == PHASE_LAST);
endmodule

// File: rtl/led_phase_scheduler.sv
// LED phase scheduler: RED/IR (optional AMB via AMBIENT_PHASE_EN)
// illumination, one ADC capture per phase, valid/ready sample stream.
`timescale 1ns/1ps
module led_phase_scheduler
  import pulseox_pkg::*;
#(
  parameter int SETTLE_CYC = 16,
  parameter int PHASE_CYC  = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DC_W-1:0]   red_dc_comp,
  input  logic [GAIN_W-1:0] red_gain,
  input  logic [DC_W-1:0]   ir_dc_comp,
  input  logic [GAIN_W-1:0] ir_gain,
  input  logic [ADC_W-1:0]  adc,
  output logic              led_red,
  output logic              led_ir,
  output logic [DC_W-1:0]   dc_comp,
  output logic [GAIN_W-1:0] pga_gain,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic [ADC_W-1:0]  smp_data,
  output logic [1:0]        smp_chan,
  output logic              overrun,
  output logic              busy
);
  localparam int CW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;

  sched_st_e r_state, w_next;
  chan_e     r_ch, w_next_ch;

  logic w_settle_done, w_phase_end;
  logic w_end, w_load, w_go_idle, w_run_start, w_cap;
  logic [DC_W-1:0]   w_dc;
  logic [GAIN_W-1:0] w_gain;

  logic              r_led_red, r_led_ir;
  logic [DC_W-1:0]   r_dc;
  logic [GAIN_W-1:0] r_gain;
  logic              r_smp_valid, r_overrun;
  logic [ADC_W-1:0]  r_smp_data;
  logic [1:0]        r_smp_chan;

  phase_timer #(
    .SETTLE_CYC(SETTLE_CYC),
    .PHASE_CYC (PHASE_CYC),
    .CW        (CW)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .i_run        (r_state != IDLE),
    .o_settle_done(w_settle_done),
    .o_phase_end  (w_phase_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ch    <= RED;
    end else begin
      r_state <= w_next;
      r_ch    <= w_next_ch;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_next_ch   = r_ch;
    w_end       = 1'b0;
    w_load      = 1'b0;
    w_go_idle   = 1'b0;
    w_run_start = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable) begin
          w_next      = SETTLE;
          w_next_ch   = RED;
          w_load      = 1'b1;
          w_run_start = 1'b1;
        end
      end
      SETTLE: begin
        if (w_settle_done) w_next = CAPTURE;
      end
      // a capture on the last cycle of a phase ends it directly
      CAPTURE: begin
        if (w_phase_end) w_end = 1'b1;
        else             w_next = DWELL;
      end
      DWELL: begin
        if (w_phase_end) w_end = 1'b1;
      end
      default: w_next = IDLE;
    endcase
    if (w_end) begin
      if (enable) begin
        w_next    = SETTLE;
        w_next_ch = next_chan(r_ch);
        w_load    = 1'b1;
      end else begin
        w_next    = IDLE;
        w_next_ch = RED;
        w_go_idle = 1'b1;
      end
    end
  end

  always_comb begin
    w_dc   = '0;
    w_gain = '0;
    unique case (w_next_ch)
      RED: begin
        w_dc   = red_dc_comp;
        w_gain = red_gain;
      end
      IR: begin
        w_dc   = ir_dc_comp;
        w_gain = ir_gain;
      end
      default: w_gain = ir_gain;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_led_red <= 1'b0;
      r_led_ir  <= 1'b0;
      r_dc      <= '0;
      r_gain    <= '0;
    end else if (w_load) begin
      r_led_red <= (w_next_ch == RED);
      r_led_ir  <= (w_next_ch == IR);
      r_dc      <= w_dc;
      r_gain    <= w_gain;
    end else if (w_go_idle) begin
      r_led_red <= 1'b0;
      r_led_ir  <= 1'b0;
      r_dc      <= '0;
      r_gain    <= '0;
    end
  end

  assign w_cap = (r_state == CAPTURE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_smp_valid <= 1'b0;
      r_smp_data  <= '0;
      r_smp_chan  <= '0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_run_start) r_overrun <= 1'b0;
      if (w_cap) begin
        if (!r_smp_valid || smp_ready) begin
          r_smp_valid <= 1'b1;
          r_smp_data  <= adc;
          r_smp_chan  <= r_ch;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (smp_ready) begin
        r_smp_valid <= 1'b0;
      end
    end
  end

  assign led_red   = r_led_red;
  assign led_ir    = r_led_ir;
  assign dc_comp   = r_dc;
  assign pga_gain  = r_gain;
  assign smp_valid = r_smp_valid;
  assign smp_data  = r_smp_data;
  assign smp_chan  = r_smp_chan;
  assign overrun   = r_overrun;
  assign busy      = (r_state != IDLE);
endmodule

// File: doc/led_phase_scheduler.md
LED_PHASE_SCHEDULER -- requirements
Module: led_phase_scheduler

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 16: cycles from phase start to ADC capture; legal range 1..PHASE_CYC-1.
REQ-002 SHALL have parameter PHASE_CYC, default 40: total cycles per LED phase.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1: run request.
REQ-006 SHALL have ports red_dc_comp (7) and red_gain (4), inputs: RED operating point.
REQ-007 SHALL have ports ir_dc_comp (7) and ir_gain (4), inputs: IR operating point.
REQ-008 SHALL have port adc, input, 8: front-end ADC sample.
REQ-009 SHALL have ports led_red and led_ir, outputs, 1 each: LED enables.
REQ-010 SHALL have ports dc_comp (7) and pga_gain (4), outputs: applied front-end settings.
REQ-011 SHALL have ports smp_valid (output, 1), smp_ready (input, 1), smp_data (output, 8) and smp_chan (output, 2; 0=RED, 1=IR, 2=AMB): sample stream to the FIR filter.
REQ-012 SHALL have port overrun, output, 1: sticky dropped-sample flag.
REQ-013 SHALL have port busy, output, 1: high whenever state is not IDLE.

Function
REQ-014 SHALL use states IDLE, SETTLE, CAPTURE and DWELL, a phase counter cnt in 0..PHASE_CYC-1, and a channel register ch.
REQ-015 IDLE with enable=1 SHALL go to SETTLE next cycle with ch=RED and cnt=0.
REQ-016 At every phase start, the block SHALL snapshot the settings for ch into dc_comp/pga_gain and drive exactly one LED; input changes mid-phase SHALL NOT affect the outputs.
REQ-017 SETTLE SHALL go to CAPTURE when cnt==SETTLE_CYC-1.
REQ-018 CAPTURE SHALL last one cycle, register adc into smp_data and ch into smp_chan, assert smp_valid the following cycle, then go to DWELL.
REQ-019 DWELL SHALL hold until cnt==PHASE_CYC-1; the next cycle SHALL start the next phase (RED->IR->RED) with cnt=0.
REQ-020 cnt SHALL increment every non-IDLE cycle and wrap to 0 at each phase start.
REQ-021 smp_valid SHALL stay high, with smp_data/smp_chan stable, until a cycle with smp_ready=1; it SHALL drop the cycle after acceptance unless a new capture coincides, in which case the new sample SHALL load and valid SHALL stay high.
REQ-022 A capture while smp_valid=1 and smp_ready=0 SHALL discard the new sample, keep the old one, and set overrun.
REQ-023 overrun SHALL clear only on rst or on an IDLE->SETTLE transition.
REQ-024 enable=0 SHALL take effect only at a phase end: the current phase completes (including its capture) and the next state is IDLE.
REQ-025 In IDLE, led_red, led_ir, dc_comp and pga_gain SHALL be 0; a pending sample SHALL remain valid until accepted.

Reset
REQ-026 rst SHALL force, immediately: state=IDLE, cnt=0, ch=RED, led_red=0, led_ir=0, dc_comp=0, pga_gain=0, smp_valid=0, smp_data=0, smp_chan=0, overrun=0, busy=0.
REQ-027 rst mid-phase SHALL discard any pending sample without a valid pulse.

Configuration
REQ-028 With AMBIENT_PHASE_EN defined, the sequence SHALL be RED->IR->AMB->RED; the AMB phase has both LEDs off, dc_comp=0, pga_gain=ir_gain, and smp_chan=2.
REQ-029 Without AMBIENT_PHASE_EN, the sequence SHALL be RED->IR only, and smp_chan SHALL never equal 2.

Structure
REQ-030 The shared package pulseox_pkg SHALL hold the channel enum (RED/IR/AMB), the scheduler state enum, and the ADC_W=8, DC_W=7 and GAIN_W=4 constants.
REQ-031 The phase counter and its end-of-phase/capture strobes SHALL be a sub-module, phase_timer.

Verification
REQ-032 rst, enable=1, ready=1, SETTLE_CYC=16, PHASE_CYC=40, red_dc_comp=0x15, adc=0x80 -> led_red=1, dc_comp=0x15 from cycle 1; smp_valid one cycle at cycle 18, smp_data=0x80, smp_chan=0.
REQ-033 Continuous run -> smp_chan alternates 0,1,0,...; valid pulses 40 cycles apart; LEDs never both high.
REQ-034 smp_ready=0 across two captures -> first sample held, overrun=1; ready=1 -> first sample accepted, valid drops.
REQ-035 enable drop at cnt=5 -> capture at cnt=16 still occurs; IDLE after cnt=39; LEDs 0.
REQ-036 rst asserted at CAPTURE -> all outputs at reset values the same cycle; no valid pulse.
REQ-037 With AMBIENT_PHASE_EN -> smp_chan sequence 0,1,2,0; both LEDs 0 during AMB.
